// File: rtl/booth_r4_seq_ctrl.sv
// Sequential radix-4 Booth multiplier controller: one shared (N+2)-bit add/sub, N/2 steps per product.
// Optional MACC_ACC_EN adds a wrapping 2N-bit accumulator on the output with an acc_clr input.
module booth_r4_seq_ctrl #(
   parameter int unsigned N = 8
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_in_valid,
   output logic           o_in_ready,
   input  logic [N-1:0]   i_a,
   input  logic [N-1:0]   i_b,
   output logic           o_out_valid,
   input  logic           i_out_ready,
   output logic [2*N-1:0] o_prod,
`ifdef MACC_ACC_EN
   input  logic           i_acc_clr,
`endif
   output logic           o_busy
);

   localparam int unsigned W     = N + 2;
   localparam int unsigned STEPS = N / 2;
   localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   if ((N % 2) != 0 || N < 4) begin : g_bad_n
      $error("booth_r4_seq_ctrl: N must be even and >= 4");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   logic [N-1:0]     r_a;
   logic [N:0]       r_b;
   logic [W-1:0]     r_hi;
   logic [N-1:0]     r_lo;
   logic [CW-1:0]    r_step;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_busy;
   logic [2*N-1:0]   r_prod;

   logic             w_run;
   logic             w_zero;
   logic             w_two;
   logic             w_neg;
   logic [W-1:0]     w_a_ext;
   logic [W-1:0]     w_a_dbl;
   logic [W-1:0]     w_opnd;
   logic [W-1:0]     w_add_a;
   logic [W-1:0]     w_add_b;
   logic             w_cin;
   logic [W-1:0]     w_sum;
   logic [W-1:0]     w_hi_next;
   logic [N-1:0]     w_lo_next;
   logic [2*N-1:0]   w_product;

   // Booth digit decode of the current multiplier triplet
   always_comb begin
      w_zero = 1'b0;
      w_two  = 1'b0;
      w_neg  = 1'b0;
      case (r_b[2:0])
         3'b000, 3'b111: w_zero = 1'b1;
         3'b001, 3'b010: ;
         3'b011:         w_two  = 1'b1;
         3'b100:         begin w_two = 1'b1; w_neg = 1'b1; end
         default:        w_neg  = 1'b1;
      endcase
   end

   // Shared adder; inputs parked at zero outside RUN to keep the unit quiet
   always_comb begin
      w_run     = (r_state == S_RUN);
      w_a_ext   = {{2{r_a[N-1]}}, r_a};
      w_a_dbl   = {r_a[N-1], r_a, 1'b0};
      w_opnd    = w_two ? w_a_dbl : w_a_ext;
      w_add_a   = w_run ? r_hi : '0;
      w_add_b   = (w_run && !w_zero) ? w_opnd : '0;
      w_cin     = w_run && !w_zero && w_neg;
      w_sum     = w_add_a + (w_cin ? ~w_add_b : w_add_b) + W'(w_cin);
      w_hi_next = {{2{w_sum[W-1]}}, w_sum[W-1:2]};
      w_lo_next = {w_sum[1:0], r_lo[N-1:2]};
      w_product = {w_hi_next[N-1:0], w_lo_next};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_step      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_prod      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
`ifdef MACC_ACC_EN
               if (i_acc_clr) r_prod <= '0;
`endif
               if (i_in_valid) begin
                  r_a        <= i_a;
                  r_b        <= {i_b, 1'b0};
                  r_hi       <= '0;
                  r_lo       <= '0;
                  r_step     <= '0;
                  r_state    <= S_RUN;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            S_RUN: begin
               r_hi   <= w_hi_next;
               r_lo   <= w_lo_next;
               r_b    <= {2'b00, r_b[N:2]};
               r_step <= r_step + CW'(1);
               if (r_step == CW'(STEPS - 1)) begin
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
`ifdef MACC_ACC_EN
                  r_prod      <= r_prod + w_product;
`else
                  r_prod      <= w_product;
`endif
               end
            end
            S_DONE: begin
               if (i_out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_busy      = r_busy;
   assign o_prod      = r_prod;

endmodule
